// File: rtl/data_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_if
//   Bundles the requester-side and DataMemory-side signals of the data memory
//   arbiter.
//   slave  : the arbiter's view (takes requests and memory read data, drives
//            grants, read returns and the memory port).
//   master : the environment's view (requesters plus the DataMemory itself).
//   Signals:
//     req/req_we          per-requester request and write enable
//     req_addr/req_wdata  packed per-requester address / write data,
//                         requester i at [i*WIDTH +: WIDTH]
//     gnt/rvalid          one-hot grant and read-return strobe per requester
//     rdata               broadcast read data, qualified by rvalid
//     mem_we/mem_addr/mem_wdata/mem_rdata   DataMemory port
// ---------------------------------------------------------------------------
interface data_mem_arbiter_if #(
  parameter int REQ_COUNT  = 2,
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 11
);
  logic [REQ_COUNT-1:0]            req;
  logic [REQ_COUNT-1:0]            req_we;
  logic [REQ_COUNT*ADDR_WIDTH-1:0] req_addr;
  logic [REQ_COUNT*DATA_WIDTH-1:0] req_wdata;
  logic [REQ_COUNT-1:0]            gnt;
  logic [REQ_COUNT-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]           rdata;
  logic                            mem_we;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [DATA_WIDTH-1:0]           mem_rdata;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//   Round-robin, burst-oriented arbiter sharing one DataMemory port (1-cycle
//   read latency) between REQ_COUNT requesters. The owner keeps the port while
//   its req stays high; once it has done MAX_BURST consecutive beats and some
//   other requester is waiting, the grant rotates.
//   Ports:
//     clock   rising-edge clock
//     reset   synchronous, active-high
//     bus     data_mem_arbiter_if.slave (requests, grants, read returns and
//             the DataMemory port)
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int REQ_COUNT  = 2,
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_BURST  = 16
) (
  input  logic               clock,
  input  logic               reset,
  data_mem_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(REQ_COUNT);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_reg, state_next;
  logic [REQ_COUNT-1:0]   gnt_reg, gnt_next;
  logic [REQ_COUNT-1:0]   rvalid_reg, rvalid_next;
  logic [IDX_W-1:0]       last_owner_reg, last_owner_next;
  logic [CNT_W-1:0]       beat_cnt_reg, beat_cnt_next;

  logic [REQ_COUNT-1:0]   beat_vec;
  logic                   beat;
  logic                   owner_req;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       search_base;
  logic [IDX_W-1:0]       winner;
  logic                   winner_found;
  logic [REQ_COUNT-1:0]   winner_onehot;

  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_wdata;

  // A beat is a granted, requesting cycle. Reset suppresses it so that no
  // write reaches memory in a cycle where reset is asserted.
  genvar gi;
  generate
    for (gi = 0; gi < REQ_COUNT; gi++) begin : g_beat
      assign beat_vec[gi]    = gnt_reg[gi] & bus.req[gi] & ~reset;
      assign rvalid_next[gi] = beat_vec[gi] & ~bus.req_we[gi];
    end
  endgenerate

  assign beat      = |beat_vec;
  assign owner_req = |(gnt_reg & bus.req);

  // Binary index of the (one-hot) grant.
  always_comb begin
    owner = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (gnt_reg[i]) owner = IDX_W'(i);
    end
  end

  // Round-robin search. While a port is owned, the search starts after the
  // owner and never returns the owner itself: the owner becomes last_owner on
  // the same edge any hand-over happens, so this is the next rotation order.
  // While idle, every requester is a candidate, starting after last_owner.
  always_comb begin
    int idx;
    idx          = 0;
    search_base  = (state_reg == OWNED) ? owner : last_owner_reg;
    winner       = '0;
    winner_found = 1'b0;
    for (int k = 1; k <= REQ_COUNT; k++) begin
      idx = (int'(search_base) + k) % REQ_COUNT;
      if (!winner_found && bus.req[idx] &&
          !((state_reg == OWNED) && (k == REQ_COUNT))) begin
        winner_found = 1'b1;
        winner       = IDX_W'(idx);
      end
    end
  end

  assign winner_onehot = REQ_COUNT'(1) << winner;

  // Memory port mux: zeros outside beats.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (beat) begin
      mem_we    = bus.req_we[owner];
      mem_addr  = bus.req_addr[owner*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata = bus.req_wdata[owner*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state logic. Release takes priority over burst rotation, so a
  // single edge performs at most one grant transition.
  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt_reg;
    last_owner_next = last_owner_reg;
    beat_cnt_next   = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (winner_found) begin
          gnt_next      = winner_onehot;
          state_next    = OWNED;
          beat_cnt_next = '0;
        end
      end
      OWNED: begin
        if (!owner_req) begin
          last_owner_next = owner;
          beat_cnt_next   = '0;
          if (winner_found) begin
            gnt_next = winner_onehot;
          end else begin
            gnt_next   = '0;
            state_next = IDLE;
          end
        end else if (beat_cnt_reg == CNT_LAST) begin
          // Burst limit reached: hand over only if someone else is waiting,
          // otherwise the counter just wraps and the owner continues.
          beat_cnt_next = '0;
          if (winner_found) begin
            gnt_next        = winner_onehot;
            last_owner_next = owner;
          end
        end else begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      gnt_reg        <= '0;
      rvalid_reg     <= '0;
      last_owner_reg <= IDX_W'(REQ_COUNT - 1);
      beat_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      gnt_reg        <= gnt_next;
      rvalid_reg     <= rvalid_next;
      last_owner_reg <= last_owner_next;
      beat_cnt_reg   <= beat_cnt_next;
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.rvalid    = rvalid_reg;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
//   Drives two requesters and a 1-cycle-latency DataMemory model around
//   data_mem_arbiter. A requester-level reference model (owner index, burst
//   count, reference memory contents) predicts grants, read returns and the
//   memory port every cycle.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;
  localparam int N   = 2;
  localparam int DW  = 36;
  localparam int AW  = 11;
  localparam int MB  = 16;
  localparam int DEP = 1 << AW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [N-1:0]    req_v   = '0;
  logic [N-1:0]    we_v    = '0;
  logic [N*AW-1:0] addr_v  = '0;
  logic [N*DW-1:0] wdata_v = '0;
  logic [DW-1:0]   mem_rdata_v;

  data_mem_arbiter_if #(.REQ_COUNT(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  assign bus.req       = req_v;
  assign bus.req_we    = we_v;
  assign bus.req_addr  = addr_v;
  assign bus.req_wdata = wdata_v;
  assign bus.mem_rdata = mem_rdata_v;

  data_mem_arbiter #(
    .REQ_COUNT(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] mem_init(int i);
    return (DW'(i) * 36'h0_9E37_79B9) ^ 36'hA_5A5A_5A5A;
  endfunction

  // DataMemory: read-first, one cycle read latency.
  logic [DW-1:0] dmem [DEP];
  initial begin
    logic [DW-1:0] rd;
    for (int i = 0; i < DEP; i++) dmem[i] = mem_init(i);
    forever begin
      @(posedge clock);
      rd = dmem[bus.mem_addr];
      if (bus.mem_we) dmem[bus.mem_addr] = bus.mem_wdata;
      mem_rdata_v <= rd;
    end
  end

  // ---------------- reference model ----------------
  int            m_owner = -1;     // -1 when nobody holds the port
  int            m_last  = N - 1;
  int            m_cnt   = 0;
  int            m_rv    = -1;     // requester whose read returns this cycle
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [DEP];

  // Next requester in round-robin order after 'base'; 'excl' drops base itself.
  function automatic int pick(int base, bit excl);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (base + k) % N;
      if (!(excl && k == N) && req_v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit exp_beat();
    return !reset && m_owner >= 0 && req_v[m_owner];
  endfunction
  function automatic logic [N-1:0] exp_gnt();
    return (m_owner < 0) ? '0 : N'(1) << m_owner;
  endfunction
  function automatic logic [N-1:0] exp_rvalid();
    return (m_rv < 0) ? '0 : N'(1) << m_rv;
  endfunction
  function automatic logic exp_we();
    return exp_beat() ? we_v[m_owner] : 1'b0;
  endfunction
  function automatic logic [AW-1:0] exp_addr();
    return exp_beat() ? addr_v[m_owner*AW +: AW] : '0;
  endfunction
  function automatic logic [DW-1:0] exp_wdata();
    return exp_beat() ? wdata_v[m_owner*DW +: DW] : '0;
  endfunction

  // Apply one clock edge to the model using the inputs presented at that edge.
  task automatic model_edge();
    int other;
    logic [AW-1:0] a;
    if (reset) begin
      m_owner = -1; m_last = N - 1; m_cnt = 0; m_rv = -1;
      return;
    end
    m_rv = -1;
    if (exp_beat()) begin
      a = addr_v[m_owner*AW +: AW];
      if (we_v[m_owner]) ref_mem[a] = wdata_v[m_owner*DW +: DW];
      else begin m_rv = m_owner; m_rdata = ref_mem[a]; end
    end
    if (m_owner < 0) begin
      m_owner = pick(m_last, 1'b0);
      m_cnt   = 0;
    end else begin
      other = pick(m_owner, 1'b1);
      if (!req_v[m_owner]) begin
        m_last  = m_owner;
        m_owner = other;
        m_cnt   = 0;
      end else if (m_cnt == MB - 1) begin
        m_cnt = 0;
        if (other >= 0) begin m_last = m_owner; m_owner = other; end
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One clock: model follows the edge; returns just after the falling edge,
  // where inputs for the next edge are set and outputs are sampled.
  task automatic step();
    model_edge();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_req(int i, bit r, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    req_v[i]             = r;
    we_v[i]              = w;
    addr_v[i*AW +: AW]   = a;
    wdata_v[i*DW +: DW]  = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    req_v = '0;
    step();
    step();
    #1;
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b want=00", bus.gnt); end
    checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b want=00", bus.rvalid); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b want=0", bus.mem_we); end
    reset = 1'b0;
    step();
    $display("test_reset: gnt=%b rvalid=%b", bus.gnt, bus.rvalid);
  endtask

  task automatic test_single_read();
    set_req(0, 1'b1, 1'b0, 11'd5, '0);
    #1;
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL sr_latency gnt got=%b want=00", bus.gnt); end
    step();
    #1;
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL sr_gnt got=%b want=01", bus.gnt); end
    checks++; if (bus.mem_addr !== 11'd5 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL sr_addr got=%0d we=%b want=5 we=0", bus.mem_addr, bus.mem_we); end
    step();
    #1;
    checks++; if (bus.rvalid !== 2'b01) begin errors++; $display("FAIL sr_rvalid got=%b want=01", bus.rvalid); end
    checks++; if (bus.rdata !== mem_init(5)) begin
      errors++; $display("FAIL sr_rdata got=%h want=%h", bus.rdata, mem_init(5)); end
    $display("test_single_read: addr=5 rdata=%h", bus.rdata);
    req_v = '0;
    step();
    step();
  endtask

  task automatic test_rr_burst();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 11'd20, '0);
    set_req(1, 1'b1, 1'b0, 11'd21, '0);
    step();
    for (int b = 0; b < MB; b++) begin
      #1;
      checks++; if (bus.gnt !== 2'b01) begin
        errors++; $display("FAIL rr_hold beat=%0d gnt got=%b want=01", b, bus.gnt); end
      step();
    end
    #1;
    checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL rr_rotate gnt got=%b want=10", bus.gnt); end
    checks++; if (bus.rvalid !== 2'b01 || bus.rdata !== m_rdata) begin
      errors++; $display("FAIL rr_last_read rvalid=%b rdata=%h want 01/%h", bus.rvalid, bus.rdata, m_rdata); end
    $display("test_rr_burst: gnt after %0d beats=%b", MB, bus.gnt);
    req_v = '0;
    step();
    step();
  endtask

  task automatic test_solo_burst();
    logic [AW-1:0] a;
    set_req(0, 1'b1, 1'b0, 11'd0, '0);
    step();
    for (int b = 0; b < 40; b++) begin
      a = AW'($urandom_range(0, DEP - 1));
      addr_v[0 +: AW] = a;
      #1;
      checks++; if (bus.gnt !== 2'b01 || bus.mem_addr !== a) begin
        errors++; $display("FAIL solo beat=%0d gnt=%b addr=%0d want 01/%0d", b, bus.gnt, bus.mem_addr, a); end
      checks++; if (bus.rvalid !== ((b > 0) ? 2'b01 : 2'b00) || (b > 0 && bus.rdata !== m_rdata)) begin
        errors++; $display("FAIL solo_read beat=%0d rvalid=%b rdata=%h want_rdata=%h", b, bus.rvalid, bus.rdata, m_rdata); end
      step();
    end
    $display("test_solo_burst: 40 beats, final gnt=%b", bus.gnt);
    req_v = '0;
    step();
    step();
  endtask

  task automatic test_write_then_read();
    set_req(1, 1'b1, 1'b1, 11'd7, 36'hABC);
    step();
    #1;
    checks++; if (bus.gnt !== 2'b10 || bus.mem_we !== 1'b1 || bus.mem_addr !== 11'd7 || bus.mem_wdata !== 36'hABC) begin
      errors++; $display("FAIL wr_port gnt=%b we=%b addr=%0d wdata=%h want 10/1/7/abc",
                         bus.gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    step();
    set_req(1, 1'b0, 1'b0, '0, '0);
    set_req(0, 1'b1, 1'b0, 11'd7, '0);
    step();
    #1;
    checks++; if (bus.gnt !== 2'b01 || bus.mem_addr !== 11'd7) begin
      errors++; $display("FAIL rd_port gnt=%b addr=%0d want 01/7", bus.gnt, bus.mem_addr); end
    step();
    #1;
    checks++; if (bus.rvalid !== 2'b01 || bus.rdata !== 36'hABC) begin
      errors++; $display("FAIL wr_rd_data rvalid=%b rdata=%h want 01/abc", bus.rvalid, bus.rdata); end
    $display("test_write_then_read: rdata=%h", bus.rdata);
    req_v = '0;
    step();
    step();
  endtask

  task automatic test_reset_mid_burst();
    set_req(0, 1'b1, 1'b0, 11'd3, '0);
    set_req(1, 1'b1, 1'b0, 11'd4, '0);
    step();
    step();
    step();
    // read in flight; now present a write while reset is high
    we_v[0] = 1'b1;
    reset   = 1'b1;
    #1;
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_no_write mem_we got=%b want=0", bus.mem_we); end
    step();
    #1;
    checks++; if (bus.gnt !== 2'b00 || bus.rvalid !== 2'b00 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL rst_mid gnt=%b rvalid=%b we=%b want 00/00/0", bus.gnt, bus.rvalid, bus.mem_we); end
    reset   = 1'b0;
    we_v[0] = 1'b0;
    step();
    #1;
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rst_regrant gnt got=%b want=01", bus.gnt); end
    $display("test_reset_mid_burst: regrant=%b", bus.gnt);
    req_v = '0;
    step();
    step();
  endtask

  task automatic test_owner_release();
    set_req(0, 1'b1, 1'b0, 11'd9, '0);
    step();
    set_req(1, 1'b1, 1'b0, 11'd10, '0);
    #1;
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rel_pre gnt got=%b want=01", bus.gnt); end
    step();
    req_v[0] = 1'b0;
    step();
    #1;
    checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL rel_switch gnt got=%b want=10", bus.gnt); end
    checks++; if (dut.last_owner_reg !== 1'b0) begin
      errors++; $display("FAIL rel_last_owner got=%0d want=0", dut.last_owner_reg); end
    $display("test_owner_release: gnt=%b", bus.gnt);
    req_v = '0;
    step();
    step();
  endtask

  task automatic test_random();
    int n_rd = 0;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (req_v[i] ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0))
          req_v[i] = ~req_v[i];
        we_v[i] = ($urandom_range(0, 2) == 0);
        addr_v[i*AW +: AW] = AW'($urandom_range(0, 31));
        wdata_v[i*DW +: DW] = {4'($urandom), 32'($urandom)};
      end
      #1;
      checks++; if (bus.gnt !== exp_gnt() || $countones(bus.gnt) > 1) begin
        errors++; $display("FAIL rnd_gnt cyc=%0d got=%b want=%b", c, bus.gnt, exp_gnt()); end
      checks++; if (bus.rvalid !== exp_rvalid()) begin
        errors++; $display("FAIL rnd_rvalid cyc=%0d got=%b want=%b", c, bus.rvalid, exp_rvalid()); end
      if (m_rv >= 0) begin
        n_rd++;
        checks++; if (bus.rdata !== m_rdata) begin
          errors++; $display("FAIL rnd_rdata cyc=%0d got=%h want=%h", c, bus.rdata, m_rdata); end
      end
      checks++; if (bus.mem_we !== exp_we() || bus.mem_addr !== exp_addr() || bus.mem_wdata !== exp_wdata()) begin
        errors++; $display("FAIL rnd_port cyc=%0d we=%b addr=%0d wdata=%h want %b/%0d/%h", c,
                           bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_we(), exp_addr(), exp_wdata()); end
      step();
    end
    reset = 1'b0;
    req_v = '0;
    step();
    $display("test_random: 600 cycles, %0d read returns checked", n_rd);
  endtask

  initial begin
    for (int i = 0; i < DEP; i++) ref_mem[i] = mem_init(i);
    @(negedge clock);
    test_reset();
    test_single_read();
    test_rr_burst();
    test_solo_burst();
    test_write_then_read();
    test_reset_mid_burst();
    test_owner_release();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
